ir_queue: RTL and testbench

Parametrised instruction register queue for the multicycle CPU datapath. It is the next generation of the single-entry instruction register. It buffers up to DEPTH fetched instruction words, each with its fetch PC, behind a valid/ready handshake. This decouples instruction-memory reads from decode and gives a flush path for taken branches, jumps and exceptions. It sits between the imem read port and the control/decode stage.

---
 rtl/ir_pkg.sv | 15 +
 rtl/ir_queue_mem.sv | 26 ++
 rtl/ir_queue.sv | 104 ++++++++++
 tb/tb_ir_queue.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared types and defaults for the instruction register queue.
package ir_pkg;

    localparam int IR_DATA_W = 32;
    localparam int IR_PC_W   = 32;
    localparam int IR_DEPTH  = 4;

    localparam logic [IR_DATA_W-1:0] IR_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [IR_PC_W-1:0]   pc;
        logic [IR_DATA_W-1:0] instr;
    } ir_entry_t;

endpackage

// File: rtl/ir_queue_mem.sv
// DEPTH-entry register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately never reset; the queue masks stale entries at its outputs.
module ir_queue_mem #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/ir_queue.sv
// Instruction register queue: DEPTH-deep FIFO of {pc, instr} with flush.
// Optional same-cycle empty-queue bypass when IR_QUEUE_BYPASS_EN is defined.
module ir_queue
    import ir_pkg::*;
#(
    parameter int DATA_W = IR_DATA_W,
    parameter int PC_W   = IR_PC_W,
    parameter int DEPTH  = IR_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [PC_W-1:0]         wr_pc,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_W-1:0]       rd_data,
    output logic [PC_W-1:0]         rd_pc,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = DATA_W + PC_W;

    logic [PW-1:0] wptr_reg, wptr_next;
    logic [PW-1:0] rptr_reg, rptr_next;
    logic          empty, full;
    logic          push, pop;
    logic          bypass_show, bypass_take;
    logic [EW-1:0] head_entry;

    assign empty = (wptr_reg == rptr_reg);
    assign full  = (wptr_reg[AW] != rptr_reg[AW]) &&
                   (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
    assign count = wptr_reg - rptr_reg;

`ifdef IR_QUEUE_BYPASS_EN
    assign bypass_show = empty && !flush && wr_valid;
`else
    assign bypass_show = 1'b0;
`endif

    assign wr_ready    = !full && !flush;
    assign rd_valid    = (!empty && !flush) || bypass_show;
    assign bypass_take = bypass_show && rd_ready;
    assign pop         = !empty && !flush && rd_ready;
    // A word consumed straight through the bypass never touches the array.
    assign push        = wr_valid && wr_ready && !bypass_take;

    ir_queue_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr_reg[AW-1:0]),
        .wdata ({wr_pc, wr_data}),
        .raddr (rptr_reg[AW-1:0]),
        .rdata (head_entry)
    );

    always_comb begin
        rd_data = DATA_W'(IR_NOP);
        rd_pc   = '0;
        if (bypass_show) begin
            rd_data = wr_data;
            rd_pc   = wr_pc;
        end else if (rd_valid) begin
            rd_data = head_entry[DATA_W-1:0];
            rd_pc   = head_entry[EW-1:DATA_W];
        end
    end

    always_comb begin
        wptr_next = wptr_reg;
        rptr_next = rptr_reg;
        if (flush) begin
            wptr_next = '0;
            rptr_next = '0;
        end else begin
            if (push) begin
                wptr_next = wptr_reg + PW'(1);
            end
            if (pop) begin
                rptr_next = rptr_reg + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            wptr_reg <= wptr_next;
            rptr_reg <= rptr_next;
        end
    end

endmodule

// File: tb/tb_ir_queue.sv
// Directed, table-driven bench for ir_queue (DEPTH=4) plus hand-written corner sequences.
module tb_ir_queue;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic [31:0] wr_pc;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic [31:0] rd_pc;
    logic        flush;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

`ifdef IR_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    ir_queue #(.DATA_W(32), .PC_W(32), .DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_pc    (wr_pc),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_pc    (rd_pc),
        .flush    (flush),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [31:0] wd;
        logic [31:0] wp;
        logic        rr;
        logic        fl;
        logic [2:0]  e_count;
        logic        e_wr_ready;
        logic        e_rd_valid;
        logic [31:0] e_rd_data;
        logic [31:0] e_rd_pc;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wv, input logic [31:0] wd, input logic [31:0] wp,
                         input logic rr, input logic fl);
        wr_valid = wv;
        wr_data  = wd;
        wr_pc    = wp;
        rd_ready = rr;
        flush    = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q_data[$];
    logic [31:0] q_pc[$];

    initial begin
        logic        exp_rv;
        logic [31:0] exp_d, exp_p;
        logic        byp;

        // idle, then push A, observe it, fill to 4, full-with-pop, flush with push+pop, illegal pop
        vecs[0]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0, 32'h0};
        vecs[1]  = '{1'b1, 32'h8C01_0004, 32'h0040_0000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h8C01_0004, 32'h0040_0000};
        vecs[3]  = '{1'b1, 32'h1111_1111, 32'h0040_0004, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h8C01_0004, 32'h0040_0000};
        vecs[4]  = '{1'b1, 32'h2222_2222, 32'h0040_0008, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 32'h8C01_0004, 32'h0040_0000};
        vecs[5]  = '{1'b1, 32'h3333_3333, 32'h0040_000C, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 32'h8C01_0004, 32'h0040_0000};
        vecs[6]  = '{1'b1, 32'h4444_4444, 32'h0040_0010, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 32'h8C01_0004, 32'h0040_0000};
        vecs[7]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 32'h1111_1111, 32'h0040_0004};
        vecs[8]  = '{1'b1, 32'h5555_5555, 32'h0040_0014, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[9]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0, 32'h0};
        vecs[10] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0, 32'h0};
        vecs[11] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0, 32'h0};

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #12;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_wr_ready", 32'(wr_ready), 32'd1);
        rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].wv, vecs[i].wd, vecs[i].wp, vecs[i].rr, vecs[i].fl);
            #2;
            exp_rv = vecs[i].e_rd_valid;
            exp_d  = vecs[i].e_rd_data;
            exp_p  = vecs[i].e_rd_pc;
            if (BYPASS && vecs[i].e_count == 3'd0 && vecs[i].wv && !vecs[i].fl) begin
                exp_rv = 1'b1;
                exp_d  = vecs[i].wd;
                exp_p  = vecs[i].wp;
            end
            $display("vec %0d: wv=%b rr=%b fl=%b count=%0d wr_ready=%b rd_valid=%b rd_data=%h rd_pc=%h",
                     i, vecs[i].wv, vecs[i].rr, vecs[i].fl, count, wr_ready, rd_valid, rd_data, rd_pc);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d_wr_ready", i), 32'(wr_ready), 32'(vecs[i].e_wr_ready));
            chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(exp_rv));
            chk($sformatf("vec%0d_rd_data", i), rd_data, exp_d);
            chk($sformatf("vec%0d_rd_pc", i), rd_pc, exp_p);
            next_cycle();
        end

        // Streaming: push and pop every cycle across pointer wrap, then one drain cycle.
        for (int i = 0; i < 11; i++) begin
            logic        wv;
            logic [31:0] wd, wp;
            wv = (i < 10);
            wd = 32'hA000_0000 + 32'(i);
            wp = 32'h0040_1000 + 32'(i * 4);
            drive(wv, wd, wp, 1'b1, 1'b0);
            #2;
            byp    = BYPASS && q_data.size() == 0 && wv;
            exp_rv = (q_data.size() > 0) || byp;
            exp_d  = (q_data.size() > 0) ? q_data[0] : (byp ? wd : 32'h0);
            exp_p  = (q_pc.size() > 0) ? q_pc[0] : (byp ? wp : 32'h0);
            $display("stream %0d: count=%0d rd_valid=%b rd_data=%h rd_pc=%h",
                     i, count, rd_valid, rd_data, rd_pc);
            chk($sformatf("stream%0d_count", i), 32'(count), 32'(q_data.size()));
            chk($sformatf("stream%0d_rd_valid", i), 32'(rd_valid), 32'(exp_rv));
            chk($sformatf("stream%0d_rd_data", i), rd_data, exp_d);
            chk($sformatf("stream%0d_rd_pc", i), rd_pc, exp_p);
            if (q_data.size() > 0) begin
                void'(q_data.pop_front());
                void'(q_pc.pop_front());
            end
            if (wv && !byp) begin
                q_data.push_back(wd);
                q_pc.push_back(wp);
            end
            next_cycle();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("stream_drained_count", 32'(count), 32'd0);
        next_cycle();

        // Asynchronous reset between edges with two entries queued.
        drive(1'b1, 32'hB000_0001, 32'h0040_2000, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 32'hB000_0002, 32'h0040_2004, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("pre_reset_count", 32'(count), 32'd2);
        rst_n = 1'b0;
        #1;
        $display("async reset: count=%0d rd_valid=%b rd_data=%h", count, rd_valid, rd_data);
        chk("async_reset_count", 32'(count), 32'd0);
        chk("async_reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("async_reset_rd_data", rd_data, 32'h0);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 32'h2002_0001, 32'h0040_3000, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        $display("post reset push: count=%0d rd_valid=%b rd_data=%h rd_pc=%h", count, rd_valid, rd_data, rd_pc);
        chk("post_reset_count", 32'(count), 32'd1);
        chk("post_reset_rd_valid", 32'(rd_valid), 32'd1);
        chk("post_reset_rd_data", rd_data, 32'h2002_0001);
        chk("post_reset_rd_pc", rd_pc, 32'h0040_3000);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        next_cycle();

        // Empty queue, push with rd_ready: bypass consumes it, otherwise it is stored.
        drive(1'b1, 32'h0000_0020, 32'h0040_4000, 1'b1, 1'b0);
        #2;
        $display("bypass probe: rd_valid=%b rd_data=%h count=%0d", rd_valid, rd_data, count);
        chk("bypass_rd_valid", 32'(rd_valid), BYPASS ? 32'd1 : 32'd0);
        chk("bypass_rd_data", rd_data, BYPASS ? 32'h0000_0020 : 32'h0);
        next_cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("bypass_count_after", 32'(count), BYPASS ? 32'd0 : 32'd1);
        chk("bypass_rd_valid_after", 32'(rd_valid), BYPASS ? 32'd0 : 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
